// File: rtl/dcache_tag_checker_pkg.sv
// +---------------------------------------------------------------------------+
// | dcache_tag_checker_pkg: widths, tag-FIFO entry layout, metadata, states    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

package dcache_tag_checker_pkg;

  localparam int ADDR_W   = 64;
  localparam int ID_W     = 16;
  localparam int TID_W    = 10;
  localparam int DATA_W   = 512;
  localparam int OFFSET_W = 6;
  localparam int INDEX_W  = 10;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  // Tag-FIFO entry is {wr, tid, addr}, shared with the index extractor.
  localparam int ENTRY_W        = ADDR_W + TID_W + 1;
  localparam int ENTRY_ADDR_LSB = 0;
  localparam int ENTRY_TID_LSB  = ADDR_W;
  localparam int ENTRY_WR_BIT   = ADDR_W + TID_W;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } meta_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_WAIT_R = 3'd2,
    S_CMP    = 3'd3,
    S_RESP   = 3'd4,
    S_RES    = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_tag_checker.sv
// +---------------------------------------------------------------------------+
// | dcache_tag_checker: pops tag-FIFO entries, compares against DRAM metadata  |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module dcache_tag_checker
  import dcache_tag_checker_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int ID_WIDTH     = ID_W,
  parameter int TID_WIDTH    = TID_W,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int OFFSET_WIDTH = OFFSET_W,
  parameter int INDEX_WIDTH  = INDEX_W,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tag_fifo_empty_i,
  output logic                              tag_fifo_rden_o,
  input  logic [ADDR_WIDTH+TID_WIDTH:0]     tag_fifo_data_i,
  input  logic [ID_WIDTH-1:0]               rid_i,
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  input  logic [TAG_WIDTH+1:0]              ruser_i,
  input  logic                              rlast_i,
  input  logic                              rvalid_i,
  output logic                              rready_o,
  output logic [ID_WIDTH-1:0]               rid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic [1:0]                        rresp_o,
  output logic                              rlast_o,
  output logic                              rvalid_o,
  input  logic                              rready_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic                              res_hit_o,
  output logic                              res_wr_o,
  output logic                              res_dirty_o,
  output logic [TID_WIDTH-1:0]              res_tid_o,
  output logic [ADDR_WIDTH-1:0]             res_addr_o,
  output logic [TAG_WIDTH-1:0]              res_victim_tag_o
);

  localparam int EW      = ADDR_WIDTH + TID_WIDTH + 1;
  localparam int TAG_LSB = INDEX_WIDTH + OFFSET_WIDTH;

  state_e                  state_q, state_d;
  logic                    rden_q, rden_d;
  logic                    rready_q, rready_d;
  logic                    first_q, first_d;
  logic                    got_q, got_d;
  logic [EW-1:0]           entry_q, entry_d;
  logic [ID_WIDTH-1:0]     beat_rid_q, beat_rid_d;
  logic [DATA_WIDTH-1:0]   beat_data_q, beat_data_d;
  logic [TAG_WIDTH+1:0]    beat_user_q, beat_user_d;
  logic                    rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]     rid_q, rid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    rlast_q, rlast_d;
  logic                    res_valid_q, res_valid_d;
  logic                    res_hit_q, res_hit_d;
  logic                    res_wr_q, res_wr_d;
  logic                    res_dirty_q, res_dirty_d;
  logic [TID_WIDTH-1:0]    res_tid_q, res_tid_d;
  logic [ADDR_WIDTH-1:0]   res_addr_q, res_addr_d;
  logic [TAG_WIDTH-1:0]    res_vtag_q, res_vtag_d;

  logic                    meta_valid;
  logic                    meta_dirty;
  logic [TAG_WIDTH-1:0]    meta_tag;
  logic [ADDR_WIDTH-1:0]   entry_addr;
  logic [TID_WIDTH-1:0]    entry_tid;
  logic                    entry_wr;
  logic                    hit;

  assign meta_valid = beat_user_q[TAG_WIDTH+1];
  assign meta_dirty = beat_user_q[TAG_WIDTH];
  assign meta_tag   = beat_user_q[TAG_WIDTH-1:0];
  assign entry_addr = entry_q[ADDR_WIDTH-1:0];
  assign entry_tid  = entry_q[ADDR_WIDTH +: TID_WIDTH];
  assign entry_wr   = entry_q[EW-1];
  assign hit        = meta_valid && (meta_tag == entry_addr[ADDR_WIDTH-1:TAG_LSB]);

  always_comb begin
    state_d     = state_q;
    rden_d      = rden_q;
    rready_d    = rready_q;
    first_d     = first_q;
    got_d       = got_q;
    entry_d     = entry_q;
    beat_rid_d  = beat_rid_q;
    beat_data_d = beat_data_q;
    beat_user_d = beat_user_q;
    rvalid_d    = rvalid_q;
    rid_d       = rid_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    res_valid_d = res_valid_q;
    res_hit_d   = res_hit_q;
    res_wr_d    = res_wr_q;
    res_dirty_d = res_dirty_q;
    res_tid_d   = res_tid_q;
    res_addr_d  = res_addr_q;
    res_vtag_d  = res_vtag_q;

    case (state_q)
      S_IDLE: begin
        if (!tag_fifo_empty_i) begin
          rden_d  = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: begin
        rden_d   = 1'b0;
        rready_d = 1'b1;
        first_d  = 1'b1;
        got_d    = 1'b0;
        state_d  = S_WAIT_R;
      end
      S_WAIT_R: begin
        // FIFO data becomes valid one cycle after the pop strobe.
        if (first_q) begin
          entry_d = tag_fifo_data_i;
          first_d = 1'b0;
        end
        if (rvalid_i && rready_q) begin
          if (!got_q) begin
            beat_rid_d  = rid_i;
            beat_data_d = rdata_i;
            beat_user_d = ruser_i;
            got_d       = 1'b1;
          end
          if (rlast_i) begin
            rready_d = 1'b0;
            state_d  = S_CMP;
          end
        end
      end
      S_CMP: begin
        res_hit_d   = hit;
        res_wr_d    = entry_wr;
        res_dirty_d = meta_valid && meta_dirty;
        res_tid_d   = entry_tid;
        res_addr_d  = entry_addr;
        res_vtag_d  = meta_tag;
        if (!entry_wr && hit) begin
          rvalid_d = 1'b1;
          rid_d    = beat_rid_q;
          rresp_d  = 2'b00;
          rlast_d  = 1'b1;
          state_d  = S_RESP;
        end else begin
          res_valid_d = 1'b1;
          state_d     = S_RES;
        end
      end
      S_RESP: begin
        if (rready_i) begin
          rvalid_d    = 1'b0;
          rlast_d     = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_RES;
        end
      end
      S_RES: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rden_q      <= 1'b0;
      rready_q    <= 1'b0;
      first_q     <= 1'b0;
      got_q       <= 1'b0;
      entry_q     <= '0;
      beat_rid_q  <= '0;
      beat_data_q <= '0;
      beat_user_q <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_wr_q    <= 1'b0;
      res_dirty_q <= 1'b0;
      res_tid_q   <= '0;
      res_addr_q  <= '0;
      res_vtag_q  <= '0;
    end else begin
      state_q     <= state_d;
      rden_q      <= rden_d;
      rready_q    <= rready_d;
      first_q     <= first_d;
      got_q       <= got_d;
      entry_q     <= entry_d;
      beat_rid_q  <= beat_rid_d;
      beat_data_q <= beat_data_d;
      beat_user_q <= beat_user_d;
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_wr_q    <= res_wr_d;
      res_dirty_q <= res_dirty_d;
      res_tid_q   <= res_tid_d;
      res_addr_q  <= res_addr_d;
      res_vtag_q  <= res_vtag_d;
    end
  end

  // The captured line is only replaced by the next lookup's beat, long after
  // the processor handshake, so it doubles as the processor R data register.
  assign rdata_o          = beat_data_q;
  assign tag_fifo_rden_o  = rden_q;
  assign rready_o         = rready_q;
  assign rid_o            = rid_q;
  assign rresp_o          = rresp_q;
  assign rlast_o          = rlast_q;
  assign rvalid_o         = rvalid_q;
  assign res_valid_o      = res_valid_q;
  assign res_hit_o        = res_hit_q;
  assign res_wr_o         = res_wr_q;
  assign res_dirty_o      = res_dirty_q;
  assign res_tid_o        = res_tid_q;
  assign res_addr_o       = res_addr_q;
  assign res_victim_tag_o = res_vtag_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_tag_checker.sv
// +---------------------------------------------------------------------------+
// | tb_dcache_tag_checker: directed vector bench for dcache_tag_checker        |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_tag_checker;
  import dcache_tag_checker_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               tag_fifo_empty_i;
  logic               tag_fifo_rden_o;
  logic [ENTRY_W-1:0] tag_fifo_data_i = '0;
  logic [ID_W-1:0]    rid_i;
  logic [DATA_W-1:0]  rdata_i;
  logic [TAG_W+1:0]   ruser_i;
  logic               rlast_i;
  logic               rvalid_i;
  logic               rready_o;
  logic [ID_W-1:0]    rid_o;
  logic [DATA_W-1:0]  rdata_o;
  logic [1:0]         rresp_o;
  logic               rlast_o;
  logic               rvalid_o;
  logic               rready_i;
  logic               res_valid_o;
  logic               res_ready_i;
  logic               res_hit_o;
  logic               res_wr_o;
  logic               res_dirty_o;
  logic [TID_W-1:0]   res_tid_o;
  logic [ADDR_W-1:0]  res_addr_o;
  logic [TAG_W-1:0]   res_victim_tag_o;

  always #5 clk = ~clk;

  dcache_tag_checker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tag_fifo_empty_i (tag_fifo_empty_i),
    .tag_fifo_rden_o  (tag_fifo_rden_o),
    .tag_fifo_data_i  (tag_fifo_data_i),
    .rid_i            (rid_i),
    .rdata_i          (rdata_i),
    .ruser_i          (ruser_i),
    .rlast_i          (rlast_i),
    .rvalid_i         (rvalid_i),
    .rready_o         (rready_o),
    .rid_o            (rid_o),
    .rdata_o          (rdata_o),
    .rresp_o          (rresp_o),
    .rlast_o          (rlast_o),
    .rvalid_o         (rvalid_o),
    .rready_i         (rready_i),
    .res_valid_o      (res_valid_o),
    .res_ready_i      (res_ready_i),
    .res_hit_o        (res_hit_o),
    .res_wr_o         (res_wr_o),
    .res_dirty_o      (res_dirty_o),
    .res_tid_o        (res_tid_o),
    .res_addr_o       (res_addr_o),
    .res_victim_tag_o (res_victim_tag_o)
  );

  // Tag FIFO model: pushed by the test, popped by the DUT strobe.
  logic [ENTRY_W-1:0] fifo_mem [16];
  int wp = 0;
  int rp = 0;
  assign tag_fifo_empty_i = (wp == rp);
  always @(posedge clk) begin
    if (tag_fifo_rden_o && (wp != rp)) begin
      tag_fifo_data_i <= fifo_mem[rp % 16];
      rp              <= rp + 1;
    end
  end

  typedef struct {
    logic             wr;
    logic [TID_W-1:0] tid;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]  rid;
    logic [DATA_W-1:0] data;
    logic [TAG_W+1:0] ruser;
    int               nbeats;
    logic             exp_r;
    logic             exp_hit;
    logic             exp_dirty;
    logic [TAG_W-1:0] exp_vtag;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout waiting, got no event expected event", name);
  endtask

  function automatic vec_t mk(input logic wr, input logic [TID_W-1:0] tid, input logic [ADDR_W-1:0] addr,
                              input logic v, input logic d, input logic [TAG_W-1:0] tag,
                              input logic [ID_W-1:0] rid, input logic [31:0] seed, input int nbeats,
                              input logic exp_r, input logic exp_hit, input logic exp_dirty);
    vec_t  t;
    meta_t m;
    m           = '{valid: v, dirty: d, tag: tag};
    t.wr        = wr;
    t.tid       = tid;
    t.addr      = addr;
    t.rid       = rid;
    t.data      = {16{seed}};
    t.ruser     = m;
    t.nbeats    = nbeats;
    t.exp_r     = exp_r;
    t.exp_hit   = exp_hit;
    t.exp_dirty = exp_dirty;
    t.exp_vtag  = tag;
    return t;
  endfunction

  task automatic push(input vec_t v);
    fifo_mem[wp % 16] = {v.wr, v.tid, v.addr};
    wp = wp + 1;
  endtask

  task automatic serve_r(input vec_t v, input int delay);
    int  g;
    bit  acc;
    g = 0;
    while (!rready_o && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (g >= 60) begin
      timeout("rready_o");
      return;
    end
    repeat (delay) @(negedge clk);
    for (int b = 0; b < v.nbeats; b++) begin
      rvalid_i = 1'b1;
      rid_i    = (b == 0) ? v.rid : ~v.rid;
      rdata_i  = (b == 0) ? v.data : ~v.data;
      ruser_i  = (b == 0) ? v.ruser : ~v.ruser;
      rlast_i  = (b == v.nbeats - 1);
      g = 0;
      acc = 1'b0;
      while (!acc && g < 60) begin
        acc = rready_o;
        @(negedge clk);
        g++;
      end
      if (!acc) timeout("r_beat_accept");
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
  endtask

  task automatic chk_res(input vec_t v);
    chk("res_valid_o", res_valid_o, 1'b1);
    chk("res_hit_o", res_hit_o, v.exp_hit);
    chk("res_wr_o", res_wr_o, v.wr);
    chk("res_dirty_o", res_dirty_o, v.exp_dirty);
    chk("res_tid_o", res_tid_o, v.tid);
    chk("res_addr_o", res_addr_o, v.addr);
    chk("res_victim_tag_o", res_victim_tag_o, v.exp_vtag);
  endtask

  task automatic collect(input vec_t v, input int rbp, input int resbp);
    int g;
    bit saw_rv;
    g = 0;
    while (!rvalid_o && !res_valid_o && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (g >= 60) begin
      timeout("result");
      return;
    end
    chk("rvalid_o", rvalid_o, v.exp_r);
    if (v.exp_r && rvalid_o) begin
      for (int k = 0; k <= rbp; k++) begin
        chk("rvalid_o_hold", rvalid_o, 1'b1);
        chk("rid_o", rid_o, v.rid);
        chk("rdata_o", rdata_o, v.data);
        chk("rresp_o", rresp_o, 2'b00);
        chk("rlast_o", rlast_o, 1'b1);
        chk("res_valid_o_early", res_valid_o, 1'b0);
        if (k < rbp) @(negedge clk);
      end
      rready_i = 1'b1;
      @(negedge clk);
      rready_i = 1'b0;
      chk("rvalid_o_after_hs", rvalid_o, 1'b0);
    end
    g = 0;
    saw_rv = 1'b0;
    while (!res_valid_o && g < 60) begin
      saw_rv |= rvalid_o;
      @(negedge clk);
      g++;
    end
    if (g >= 60) begin
      timeout("res_valid_o");
      return;
    end
    chk("rvalid_o_during_res", saw_rv | rvalid_o, 1'b0);
    for (int k = 0; k <= resbp; k++) begin
      chk_res(v);
      if (k < resbp) @(negedge clk);
    end
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    chk("res_valid_o_after_hs", res_valid_o, 1'b0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rden"}, tag_fifo_rden_o, 1'b0);
    chk({pfx, "_rready"}, rready_o, 1'b0);
    chk({pfx, "_rvalid"}, rvalid_o, 1'b0);
    chk({pfx, "_rid"}, rid_o, '0);
    chk({pfx, "_rdata"}, rdata_o, '0);
    chk({pfx, "_rresp"}, rresp_o, '0);
    chk({pfx, "_rlast"}, rlast_o, 1'b0);
    chk({pfx, "_res_valid"}, res_valid_o, 1'b0);
    chk({pfx, "_res_hit"}, res_hit_o, 1'b0);
    chk({pfx, "_res_wr"}, res_wr_o, 1'b0);
    chk({pfx, "_res_dirty"}, res_dirty_o, 1'b0);
    chk({pfx, "_res_tid"}, res_tid_o, '0);
    chk({pfx, "_res_addr"}, res_addr_o, '0);
    chk({pfx, "_res_vtag"}, res_victim_tag_o, '0);
  endtask

  vec_t vecs [8];
  vec_t ord  [3];
  int   dly  [3];

  initial begin
    // wr, tid, addr, valid, dirty, tag, rid, seed, beats, exp_r, exp_hit, exp_dirty
    vecs[0] = mk(1'b0, 10'd5,   64'h1234_5678_9ABC_0040, 1'b1, 1'b0, 48'h1234_5678_9ABC, 16'h00A1, 32'hC0DE_0001, 1, 1'b1, 1'b1, 1'b0);
    vecs[1] = mk(1'b0, 10'd5,   64'h1234_5678_9ABC_0040, 1'b1, 1'b1, 48'hDEAD_BEEF_0000, 16'h00A2, 32'hC0DE_0002, 1, 1'b0, 1'b0, 1'b1);
    vecs[2] = mk(1'b1, 10'd0,   64'h1234_5678_9ABC_0040, 1'b1, 1'b0, 48'h1234_5678_9ABC, 16'h00A3, 32'hC0DE_0003, 1, 1'b0, 1'b1, 1'b0);
    vecs[3] = mk(1'b0, 10'd17,  64'h1234_5678_9ABC_0040, 1'b0, 1'b1, 48'h1234_5678_9ABC, 16'h00A4, 32'hC0DE_0004, 1, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk(1'b0, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFE, 16'hFFFF, 32'hC0DE_0005, 1, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk(1'b0, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 16'h5A5A, 32'hC0DE_0006, 1, 1'b1, 1'b1, 1'b1);
    vecs[6] = mk(1'b1, 10'h2A3, 64'h0000_0000_0001_FFC0, 1'b1, 1'b1, 48'h0000_0000_0002, 16'h0007, 32'hC0DE_0007, 1, 1'b0, 1'b0, 1'b1);
    vecs[7] = mk(1'b0, 10'd99,  64'hABCD_0000_0000_FFFF, 1'b1, 1'b0, 48'hABCD_0000_0000, 16'h1234, 32'hC0DE_0008, 3, 1'b1, 1'b1, 1'b0);

    rst_n       = 1'b0;
    rid_i       = '0;
    rdata_i     = '0;
    ruser_i     = '0;
    rlast_i     = 1'b0;
    rvalid_i    = 1'b0;
    rready_i    = 1'b0;
    res_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Stray beats while the FIFO is empty must not be accepted.
    rvalid_i = 1'b1;
    rlast_i  = 1'b1;
    rdata_i  = {16{32'hBAD0_BAD0}};
    ruser_i  = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stray_rready_o", rready_o, 1'b0);
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    chk("stray_res_valid_o", res_valid_o, 1'b0);

    for (int i = 0; i < 8; i++) begin
      push(vecs[i]);
      serve_r(vecs[i], i % 3);
      collect(vecs[i], 0, 0);
    end

    // Back-pressure on both output channels.
    push(vecs[0]);
    serve_r(vecs[0], 1);
    collect(vecs[0], 5, 3);

    // Three queued entries with varied R latency; results come out in order.
    ord[0] = mk(1'b0, 10'd1, 64'h0000_1111_2222_0080, 1'b1, 1'b0, 48'h0000_1111_2222, 16'h0101, 32'h1111_0001, 2, 1'b1, 1'b1, 1'b0);
    ord[1] = mk(1'b1, 10'd2, 64'h0000_3333_4444_00C0, 1'b1, 1'b1, 48'h0000_3333_4445, 16'h0202, 32'h2222_0002, 1, 1'b0, 1'b0, 1'b1);
    ord[2] = mk(1'b0, 10'd3, 64'h0000_5555_6666_0100, 1'b0, 1'b0, 48'h0000_5555_6666, 16'h0303, 32'h3333_0003, 1, 1'b0, 1'b0, 1'b0);
    dly[0] = 4;
    dly[1] = 0;
    dly[2] = 2;
    for (int i = 0; i < 3; i++) push(ord[i]);
    for (int i = 0; i < 3; i++) begin
      serve_r(ord[i], dly[i]);
      collect(ord[i], i, 1);
    end

    // Reset during S_WAIT_R, then a normal lookup.
    push(vecs[5]);
    begin
      int g;
      g = 0;
      while (!rready_o && g < 60) begin
        @(negedge clk);
        g++;
      end
      if (g >= 60) timeout("rready_o_before_reset");
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle_rready", rready_o, 1'b0);
    push(vecs[0]);
    serve_r(vecs[0], 0);
    collect(vecs[0], 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
